sha1_job_scheduler: RTL and testbench
=====================================

// Module: sha1_job_scheduler
// PURPOSE
// Shares one SHA1_hash core among NREQ requesters. Round-robin arbitration picks one pending job (dpsram address + byte size),
// issues start to the core, and waits for the core's level-type done. It then returns the 160-bit digest to the owning requester
// over a valid/ready response channel. A watchdog aborts jobs that never complete.
// PARAMETERS
// NREQ      4       number of requesters (2..8); ID width IDW = clog2(NREQ)
// MASK_CYC  2       cycles after core_start during which core_done is ignored (done is stale from previous job)
// TMO_W     16      watchdog counter width; timeout fires at 2**TMO_W-1 cycles in BUSY
// PORTS
// clk          in   1          clock; also the core/dpsram clock domain
// nreset       in   1          asynchronous, active-low reset
// req_valid    in   NREQ       per-requester job pending
// req_addr     in   NREQ*32    flattened start addresses, requester i at [32i+:32]
// req_size     in   NREQ*32    flattened message sizes in bytes
// req_ready    out  NREQ       one-hot accept; job i is taken when req_valid[i]&req_ready[i]
// resp_valid   out  1          digest/result available
// resp_ready   in   1          consumer accepts response
// resp_id      out  IDW        requester index owning the response
// resp_hash    out  160        digest {h0..h4}; zero when resp_err
// resp_err     out  1          job aborted by watchdog
// core_start   out  1          one-cycle start pulse to SHA1_hash.start_hash
// core_addr    out  32         to SHA1_hash.message_addr; held stable from start until response accepted
// core_size    out  32         to SHA1_hash.message_size; held stable likewise
// core_done    in   1          SHA1_hash.done (level)
// core_hash    in   160        SHA1_hash.hash
// busy         out  1          high in any state other than IDLE
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, all outputs 0 (req_ready, resp_*, core_start, core_addr, core_size, busy).
// - FSM IDLE->START->MASK->BUSY->RESP->IDLE.
// - IDLE: if any req_valid, grant = first set bit searching from rr_ptr upward with wrap. req_ready[grant]=1 combinationally
//   (at most one bit). On that edge, latch id/addr/size into core_addr/core_size and go to START. No request: stay.
// - START: core_start=1 for exactly this cycle. Go to MASK; load mask counter with MASK_CYC-1.
// - MASK: core_done ignored. Decrement each cycle; at 0 go to BUSY and clear watchdog.
// - BUSY: watchdog increments each cycle.
//   - core_done=1: capture core_hash into resp_hash, resp_err=0, go to RESP.
//   - Watchdog all-ones: resp_hash=0, resp_err=1, go to RESP.
//   - core_done wins if both occur in the same cycle.
// - RESP: resp_valid=1, resp_id/resp_hash/resp_err stable until resp_valid&resp_ready.
//   - On accept: rr_ptr = (id+1) mod NREQ, go to IDLE; resp_valid drops next cycle.
// - Throughput: a new grant is possible in the cycle after RESP accept; no request is accepted outside IDLE.
// - Requesters holding req_valid while not granted keep waiting. A request deasserted before grant is dropped silently.
// - Starvation bound: a continuously valid requester is granted within NREQ jobs.
// - Size 0 is forwarded unchanged; the core defines the digest.
// - nreset mid-job returns to IDLE immediately. The core must be reset by the same nreset; no abort is sent otherwise.
// - resp_id counts 0..NREQ-1; rr_ptr wraps at NREQ (non-power-of-two NREQ must wrap correctly).
// TESTING
// - Single job: req_valid=4'b0001, addr=0, size=3 ("abc") -> one core_start pulse; resp_id=0,
//   resp_hash=a9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d, resp_err=0.
// - Fairness: req_valid=4'b1111 held, resp_ready=1 -> grant order 0,1,2,3,0; no requester served twice before all served.
// - Stale done: core_done tied high from previous job -> no response before MASK_CYC+1 cycles after core_start;
//   resp_hash equals the new digest.
// - Backpressure: resp_ready=0 for 20 cycles -> resp_valid/resp_id/resp_hash stable; no req_ready asserted; accept -> IDLE.
// - Timeout (TMO_W=4): core_done stuck low -> resp_err=1, resp_hash=0 exactly 15 cycles into BUSY.
// - Reset mid-BUSY: nreset low -> all outputs 0 asynchronously; after release, a pending req 2 is granted first (rr_ptr=0 search).

Source files
------------

// File: rtl/sha1_job_scheduler_if.sv
// Request/response bundle between requesters and the shared SHA-1 job scheduler.
// The master drives jobs and accepts responses; the slave is the scheduler.
interface sha1_job_scheduler_if #(
   parameter int NREQ = 4
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Both channels use valid/ready: a transfer happens on a rising clk edge where
   // valid and ready are both high; valid and its payload hold until that edge.
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*32-1:0] req_addr;
   logic [NREQ*32-1:0] req_size;
   logic [NREQ-1:0]    req_ready;
   logic               resp_valid;
   logic               resp_ready;
   logic [IDW-1:0]     resp_id;
   logic [159:0]       resp_hash;
   logic               resp_err;

   modport master (
      output req_valid, req_addr, req_size, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_hash, resp_err
   );

   modport slave (
      input  req_valid, req_addr, req_size, resp_ready,
      output req_ready, resp_valid, resp_id, resp_hash, resp_err
   );
endinterface

// File: rtl/sha1_job_scheduler.sv
// Round-robin scheduler sharing one SHA1_hash core among NREQ requesters,
// with a start-masking window for stale done and a watchdog abort.
module sha1_job_scheduler #(
   parameter int NREQ     = 4,
   parameter int MASK_CYC = 2,
   parameter int TMO_W    = 16
) (
   input  logic                 clk,
   input  logic                 nreset,
   sha1_job_scheduler_if.slave  bus,
   output logic                 core_start,
   output logic [31:0]          core_addr,
   output logic [31:0]          core_size,
   input  logic                 core_done,
   input  logic [159:0]         core_hash,
   output logic                 busy
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int MW  = (MASK_CYC > 1) ? $clog2(MASK_CYC) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_MASK  = 3'd2;
   localparam logic [2:0] S_BUSY  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;

   logic [2:0]       state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   id;
   logic [MW-1:0]    mask_cnt;
   logic [TMO_W-1:0] wdog;
   logic [TMO_W-1:0] wdog_next;
   logic [159:0]     hash_q;
   logic             err_q;

   logic             grant_any;
   logic [IDW-1:0]   grant_id;
   logic [31:0]      grant_addr;
   logic [31:0]      grant_size;

   // Scan offsets from far to near so the closest pending requester at or after rr_ptr wins.
   always_comb begin
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      grant_any = 1'b0;
      grant_id  = '0;
      sum       = '0;
      idx       = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         sum = {1'b0, rr_ptr} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
         idx = sum[IDW-1:0];
         if (bus.req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = idx;
         end
      end
   end

   always_comb begin
      grant_addr = '0;
      grant_size = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (grant_id == IDW'(j)) begin
            grant_addr = bus.req_addr[32*j +: 32];
            grant_size = bus.req_size[32*j +: 32];
         end
      end
   end

   // Gated by nreset so no accept is offered while reset is held.
   always_comb begin
      bus.req_ready = '0;
      if (nreset && state == S_IDLE && grant_any) bus.req_ready[grant_id] = 1'b1;
   end

   assign wdog_next      = wdog + TMO_W'(1);
   assign core_start     = (state == S_START);
   assign busy           = (state != S_IDLE);
   assign bus.resp_valid = (state == S_RESP);
   assign bus.resp_id    = id;
   assign bus.resp_hash  = hash_q;
   assign bus.resp_err   = err_q;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         id        <= '0;
         mask_cnt  <= '0;
         wdog      <= '0;
         hash_q    <= '0;
         err_q     <= 1'b0;
         core_addr <= '0;
         core_size <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  id        <= grant_id;
                  core_addr <= grant_addr;
                  core_size <= grant_size;
                  state     <= S_START;
               end
            end
            S_START: begin
               mask_cnt <= MW'(MASK_CYC - 1);
               state    <= S_MASK;
            end
            S_MASK: begin
               if (mask_cnt == '0) begin
                  wdog  <= '0;
                  state <= S_BUSY;
               end else begin
                  mask_cnt <= mask_cnt - MW'(1);
               end
            end
            S_BUSY: begin
               wdog <= wdog_next;
               // A real completion takes priority over a watchdog expiry in the same cycle.
               if (core_done) begin
                  hash_q <= core_hash;
                  err_q  <= 1'b0;
                  state  <= S_RESP;
               end else if (&wdog_next) begin
                  hash_q <= '0;
                  err_q  <= 1'b1;
                  state  <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  rr_ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha1_job_scheduler.sv
// Bench for sha1_job_scheduler: fixed grant-order table, corner-case sequences,
// then randomized jobs checked against a round-robin reference model.
module tb_sha1_job_scheduler;
   localparam int NREQ     = 4;
   localparam int MASK_CYC = 2;
   localparam int TMO_W    = 4;
   localparam logic [159:0] ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

   logic         clk;
   logic         nreset;
   logic         core_start;
   logic [31:0]  core_addr;
   logic [31:0]  core_size;
   logic         core_done;
   logic [159:0] core_hash;
   logic         busy;

   sha1_job_scheduler_if #(.NREQ(NREQ)) bus ();

   sha1_job_scheduler #(.NREQ(NREQ), .MASK_CYC(MASK_CYC), .TMO_W(TMO_W)) dut (
      .clk        (clk),
      .nreset     (nreset),
      .bus        (bus.slave),
      .core_start (core_start),
      .core_addr  (core_addr),
      .core_size  (core_size),
      .core_done  (core_done),
      .core_hash  (core_hash),
      .busy       (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   // ---------------- state shared by tasks ----------------
   int           n_vec = 0;
   int           n_err = 0;
   int           rr = 0;
   int           start_cnt = 0;
   int           core_lat = 1;
   bit           core_stale = 0;
   logic [31:0]  addr_arr[NREQ];
   logic [31:0]  size_arr[NREQ];
   logic [159:0] exp_q[$];

   typedef struct {
      logic [3:0] valid;
      int         exp_id;
   } vec_t;
   vec_t tbl[10];

   // Stand-in for the hash core: level done, digest derived from the job descriptor.
   function automatic logic [159:0] model_hash(input logic [31:0] a, input logic [31:0] s);
      if (a == 32'd0 && s == 32'd3) return ABC;
      return {a, s, a ^ 32'h5a5a5a5a, a + s, ~s};
   endfunction

   int          cnt;
   logic [31:0] lat_addr, lat_size;
   always @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cnt       <= 0;
         core_done <= 1'b0;
         core_hash <= '0;
      end else if (core_start) begin
         cnt      <= core_lat;
         lat_addr <= core_addr;
         lat_size <= core_size;
         if (!core_stale) core_done <= 1'b0;
      end else if (cnt > 0) begin
         cnt <= cnt - 1;
         if (cnt == 1) begin
            core_done <= 1'b1;
            core_hash <= model_hash(lat_addr, lat_size);
         end
      end
   end

   always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

   // ---------------- reference model ----------------
   function automatic int ref_grant(input logic [3:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // ---------------- scoreboard / drivers ----------------
   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_addrs();
      for (int i = 0; i < NREQ; i++) begin
         addr_arr[i] = $urandom | 32'h10;
         size_arr[i] = $urandom_range(0, 4096);
         bus.req_addr[32*i +: 32] = addr_arr[i];
         bus.req_size[32*i +: 32] = size_arr[i];
      end
   endtask

   task automatic run_job(input logic [3:0] valid, input int exp_id, input int lat, input int bp,
                          input bit stale, input bit hold, input bit exp_err, output logic [159:0] got);
      logic [3:0]   exp_rdy;
      logic [159:0] eh, h0;
      logic [1:0]   id0, eid;
      logic [31:0]  ea, es;
      int           n, cyc, sc0, exp_cyc;
      bit           stable, noacc;
      core_lat   = lat;
      core_stale = stale;
      @(negedge clk);
      bus.req_valid = valid;
      #1;
      n = 0;
      while (bus.req_ready == 4'b0 && n < 5) begin
         @(negedge clk); #1; n++;
      end
      exp_rdy = 4'b0001 << exp_id;
      chk("req_ready_grant", bus.req_ready, exp_rdy);
      ea = addr_arr[exp_id];
      es = size_arr[exp_id];
      eh = exp_err ? 160'd0 : model_hash(ea, es);
      exp_q.push_back(eh);
      sc0 = start_cnt;
      @(negedge clk);
      bus.req_valid = hold ? 4'hf : 4'h0;
      #1;
      chk("core_start", core_start, 1'b1);
      chk("core_addr", core_addr, ea);
      chk("core_size", core_size, es);
      cyc   = 0;
      noacc = 1;
      while (!bus.resp_valid && cyc < 40) begin
         @(negedge clk); #1; cyc++;
         if (bus.req_ready != 4'b0) noacc = 0;
      end
      exp_cyc = exp_err ? (1 + MASK_CYC + (2**TMO_W - 1))
                        : ((lat + 2 > MASK_CYC + 2) ? lat + 2 : MASK_CYC + 2);
      chk("resp_latency", cyc, exp_cyc);
      h0     = bus.resp_hash;
      id0    = bus.resp_id;
      stable = 1;
      for (int k = 0; k < bp; k++) begin
         @(negedge clk); #1;
         if (!bus.resp_valid || bus.resp_hash !== h0 || bus.resp_id !== id0) stable = 0;
         if (bus.req_ready != 4'b0) noacc = 0;
      end
      if (bp > 0) chk("resp_stable", stable, 1'b1);
      chk("no_grant_while_busy", noacc, 1'b1);
      eid = exp_id[1:0];
      chk("resp_id", bus.resp_id, eid);
      chk("resp_hash", bus.resp_hash, exp_q.pop_front());
      chk("resp_err", bus.resp_err, exp_err);
      got = bus.resp_hash;
      bus.resp_ready = 1'b1;
      bus.req_valid  = 4'h0;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      #1;
      chk("resp_valid_drop", bus.resp_valid, 1'b0);
      chk("idle_after_accept", busy, 1'b0);
      chk("start_pulses", start_cnt - sc0, 1);
      rr = (exp_id + 1) % NREQ;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [159:0] got;
      logic [3:0]   v;
      int           e, lat;
      bit           st;

      tbl[0] = '{4'b0001, 0};
      tbl[1] = '{4'b1111, 1};
      tbl[2] = '{4'b1111, 2};
      tbl[3] = '{4'b1111, 3};
      tbl[4] = '{4'b1111, 0};
      tbl[5] = '{4'b1001, 3};
      tbl[6] = '{4'b0110, 1};
      tbl[7] = '{4'b0001, 0};
      tbl[8] = '{4'b1000, 3};
      tbl[9] = '{4'b0100, 2};

      nreset         = 1'b1;
      bus.req_valid  = 4'h0;
      bus.resp_ready = 1'b0;
      set_addrs();
      #2 nreset = 1'b0;
      bus.req_valid = 4'hf;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", bus.req_ready, 4'h0);
      chk("rst_resp_valid", bus.resp_valid, 1'b0);
      chk("rst_resp_id", bus.resp_id, 2'd0);
      chk("rst_resp_hash", bus.resp_hash, 160'd0);
      chk("rst_resp_err", bus.resp_err, 1'b0);
      chk("rst_core_start", core_start, 1'b0);
      chk("rst_core_addr", core_addr, 32'd0);
      chk("rst_core_size", core_size, 32'd0);
      chk("rst_busy", busy, 1'b0);
      bus.req_valid = 4'h0;
      @(negedge clk);
      nreset = 1'b1;
      rr = 0;

      // Fixed grant order from rr_ptr=0, including fairness and wrap.
      for (int i = 0; i < 10; i++) begin
         set_addrs();
         run_job(tbl[i].valid, tbl[i].exp_id, $urandom_range(1, 6), 0, 0, 0, 0, got);
      end

      // Known digest for "abc" passes through unchanged.
      addr_arr[0] = 32'd0;
      size_arr[0] = 32'd3;
      bus.req_addr[31:0] = 32'd0;
      bus.req_size[31:0] = 32'd3;
      run_job(4'b0001, ref_grant(4'b0001, rr), 3, 0, 0, 0, 0, got);
      chk("abc_digest", got, ABC);

      // Done still high from the previous job must not be taken as completion.
      set_addrs();
      run_job(4'b0010, ref_grant(4'b0010, rr), 2, 0, 1, 0, 0, got);

      // Backpressure with all requesters pending.
      set_addrs();
      run_job(4'b0001, ref_grant(4'b0001, rr), 2, 20, 0, 1, 0, got);

      // Watchdog abort.
      set_addrs();
      run_job(4'b1000, ref_grant(4'b1000, rr), 0, 0, 0, 0, 1, got);

      // Reset mid-job; leave rr_ptr at 3 first so a reset pointer is observable.
      set_addrs();
      run_job(4'b0100, ref_grant(4'b0100, rr), $urandom_range(1, 5), 0, 0, 0, 0, got);
      core_lat   = 0;
      core_stale = 0;
      @(negedge clk);
      bus.req_valid = 4'b0001;
      #1;
      chk("pre_reset_grant", bus.req_ready, 4'b0001);
      @(negedge clk);
      bus.req_valid = 4'h0;
      repeat (6) @(negedge clk);
      #1;
      chk("busy_before_reset", busy, 1'b1);
      bus.req_valid = 4'b1100;
      nreset = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_resp_valid", bus.resp_valid, 1'b0);
      chk("midrst_core_addr", core_addr, 32'd0);
      chk("midrst_core_size", core_size, 32'd0);
      chk("midrst_req_ready", bus.req_ready, 4'h0);
      @(negedge clk);
      nreset = 1'b1;
      bus.req_valid = 4'h0;
      rr = 0;
      run_job(4'b1100, 2, 2, 0, 0, 0, 0, got);

      // Randomized jobs against the reference model.
      for (int j = 0; j < 40; j++) begin
         set_addrs();
         v   = 4'($urandom_range(1, 15));
         e   = ref_grant(v, rr);
         st  = ($urandom_range(0, 3) == 0);
         lat = st ? $urandom_range(1, 2) : $urandom_range(1, 9);
         run_job(v, e, lat, $urandom_range(0, 3), st, 0, 0, got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
